// File: rtl/dmem_arbiter.sv
// Round-robin req/ack arbiter that shares the single-port data memory between
// the core (port 0) and the loader/DMA engine (port 1). All outputs are registered.
module dmem_arbiter #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req0,
  input  logic              we0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] wdata0,
  output logic              ack0,
  output logic [DATA_W-1:0] rdata0,
  input  logic              req1,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata1,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic [CNT_W-1:0]  cnt0,
  output logic [CNT_W-1:0]  cnt1
);

  typedef enum logic [1:0] {IDLE, SERVE, ACK} state_e;

  state_e              state_q, state_d;
  logic                last_gnt_q, last_gnt_d;
  logic                gnt_id_q, gnt_id_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_write_q, mem_write_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                busy_q, busy_d;
  logic [CNT_W-1:0]    cnt0_q, cnt0_d, cnt1_q, cnt1_d;
  logic                pick;

  always_comb begin
    state_d     = state_q;
    last_gnt_d  = last_gnt_q;
    gnt_id_d    = gnt_id_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_write_d = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    cnt0_d      = cnt0_q;
    cnt1_d      = cnt1_q;
    pick        = 1'b0;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          // On a tie the port that did not win last time is served.
          pick        = (req0 && req1) ? ~last_gnt_q : req1;
          gnt_id_d    = pick;
          last_gnt_d  = pick;
          mem_write_d = pick ? we1 : we0;
          mem_addr_d  = pick ? addr1 : addr0;
          mem_wdata_d = pick ? wdata1 : wdata0;
          state_d     = SERVE;
        end
      end
      SERVE: begin
        if (!mem_write_q) begin
          if (gnt_id_q) rdata1_d = mem_rdata;
          else          rdata0_d = mem_rdata;
        end
        ack0_d  = ~gnt_id_q;
        ack1_d  = gnt_id_q;
        state_d = ACK;
      end
      ACK: begin
        if (gnt_id_q) cnt1_d = (cnt1_q == '1) ? cnt1_q : cnt1_q + 1'b1;
        else          cnt0_d = (cnt0_q == '1) ? cnt0_q : cnt0_q + 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      last_gnt_q  <= 1'b1;
      gnt_id_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_write_q <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      busy_q      <= 1'b0;
      cnt0_q      <= '0;
      cnt1_q      <= '0;
    end else begin
      state_q     <= state_d;
      last_gnt_q  <= last_gnt_d;
      gnt_id_q    <= gnt_id_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_write_q <= mem_write_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      busy_q      <= busy_d;
      cnt0_q      <= cnt0_d;
      cnt1_q      <= cnt1_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_write = mem_write_q;
  assign rdata0    = rdata0_q;
  assign rdata1    = rdata1_q;
  assign ack0      = ack0_q;
  assign ack1      = ack1_q;
  assign busy      = busy_q;
  assign cnt0      = cnt0_q;
  assign cnt1      = cnt1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a per-cycle vector table plus hand-written
// sequences for late requests, asynchronous reset and counter saturation.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
  logic [4:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1, mem_write, busy;
  logic [15:0] rdata0, rdata1, mem_wdata, mem_rdata;
  logic [4:0]  mem_addr;
  logic [7:0]  cnt0, cnt1;

  logic        s_req0 = 1'b0;
  logic [4:0]  s_addr0 = 5'd2;
  logic [15:0] s_mem_rdata = 16'h5A5A;
  logic        s_ack0, s_ack1, s_mem_write, s_busy;
  logic [15:0] s_rdata0, s_rdata1, s_mem_wdata;
  logic [4:0]  s_mem_addr;
  logic [1:0]  s_cnt0, s_cnt1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  dmem_arbiter dut (
    .clock(clk), .reset(reset),
    .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
    .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
  );

  dmem_arbiter #(.CNT_W(2)) dut_s (
    .clock(clk), .reset(reset),
    .req0(s_req0), .we0(1'b0), .addr0(s_addr0), .wdata0(16'h0000), .ack0(s_ack0), .rdata0(s_rdata0),
    .req1(1'b0), .we1(1'b0), .addr1(5'd0), .wdata1(16'h0000), .ack1(s_ack1), .rdata1(s_rdata1),
    .mem_addr(s_mem_addr), .mem_wdata(s_mem_wdata), .mem_write(s_mem_write), .mem_rdata(s_mem_rdata),
    .busy(s_busy), .cnt0(s_cnt0), .cnt1(s_cnt1)
  );

  // Memory model: preloaded with 16'h1000+index on the first edge, then written by the DUT.
  logic [15:0] mem [32];
  logic        mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
      mem_ready <= 1'b1;
    end else if (mem_write) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        rst;
    logic        req0, we0;
    logic [4:0]  addr0;
    logic [15:0] wdata0;
    logic        req1, we1;
    logic [4:0]  addr1;
    logic [15:0] wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic        mw;
    logic [4:0]  ma;
    logic [15:0] mwd;
    logic        busy;
    logic [7:0]  c0, c1;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack_exclusive", {62'd0, ack0, ack1} == 64'd3, 64'd0);
  endtask

  initial begin
    //            rst r0 w0 a0 wd0       r1 w1 a1 wd1        ak0 ak1 rd0       rd1       mw ma mwd       bsy c0 c1
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0});
    vecs.push_back('{0, 1, 1, 5, 16'hBEEF, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 1, 5, 16'hBEEF, 1, 0, 0});
    vecs.push_back('{0, 1, 1, 5, 16'hBEEF, 0, 0, 0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 0, 5, 16'hBEEF, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 5, 16'hBEEF, 0, 1, 0});
    vecs.push_back('{0, 1, 0, 5, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 5, 16'h0000, 1, 1, 0});
    vecs.push_back('{0, 1, 0, 5, 16'h0000, 0, 0, 0, 16'h0000, 1, 0, 16'hBEEF, 16'h0000, 0, 5, 16'h0000, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'hBEEF, 16'h0000, 0, 5, 16'h0000, 0, 2, 0});
    vecs.push_back('{1, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0, 0, 0});
    vecs.push_back('{0, 1, 0, 3, 16'h0000, 1, 1, 7, 16'h1234, 0, 0, 16'h0000, 16'h0000, 0, 3, 16'h0000, 1, 0, 0});
    vecs.push_back('{0, 1, 0, 3, 16'h0000, 1, 1, 7, 16'h1234, 1, 0, 16'h1003, 16'h0000, 0, 3, 16'h0000, 1, 0, 0});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 1, 1, 7, 16'h1234, 0, 0, 16'h1003, 16'h0000, 0, 3, 16'h0000, 0, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 1, 1, 7, 16'h1234, 0, 0, 16'h1003, 16'h0000, 1, 7, 16'h1234, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 1, 1, 7, 16'h1234, 0, 1, 16'h1003, 16'h0000, 0, 7, 16'h1234, 1, 1, 0});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h1003, 16'h0000, 0, 7, 16'h1234, 0, 1, 1});
    // Both ports hold load requests for 12 cycles: grants go 0,1,0,1.
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1003, 16'h0000, 0, 7, 16'h0000, 1, 1, 1});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 1, 0, 16'h1234, 16'h0000, 0, 7, 16'h0000, 1, 1, 1});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 7, 16'h0000, 0, 2, 1});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1234, 16'h0000, 0, 5, 16'h0000, 1, 2, 1});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 1, 16'h1234, 16'hBEEF, 0, 5, 16'h0000, 1, 2, 1});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 5, 16'h0000, 0, 2, 2});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 7, 16'h0000, 1, 2, 2});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 1, 0, 16'h1234, 16'hBEEF, 0, 7, 16'h0000, 1, 2, 2});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 7, 16'h0000, 0, 3, 2});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 5, 16'h0000, 1, 3, 2});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 1, 16'h1234, 16'hBEEF, 0, 5, 16'h0000, 1, 3, 2});
    vecs.push_back('{0, 1, 0, 7, 16'h0000, 1, 0, 5, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 5, 16'h0000, 0, 3, 3});
    vecs.push_back('{0, 0, 0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 16'h1234, 16'hBEEF, 0, 5, 16'h0000, 0, 3, 3});

    foreach (vecs[i]) begin
      reset  = vecs[i].rst;
      req0   = vecs[i].req0;  we0 = vecs[i].we0;  addr0 = vecs[i].addr0;  wdata0 = vecs[i].wdata0;
      req1   = vecs[i].req1;  we1 = vecs[i].we1;  addr1 = vecs[i].addr1;  wdata1 = vecs[i].wdata1;
      tick();
      chk($sformatf("vec%0d", i),
          {ack0, ack1, rdata0, rdata1, mem_write, mem_addr, mem_wdata, busy, cnt0, cnt1},
          {vecs[i].ack0, vecs[i].ack1, vecs[i].rdata0, vecs[i].rdata1, vecs[i].mw, vecs[i].ma,
           vecs[i].mwd, vecs[i].busy, vecs[i].c0, vecs[i].c1});
    end

    // Port 1 raises its request during port 0's SERVE cycle.
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd3; wdata0 = '0;
    tick();
    chk("late_grant0", {busy, mem_addr}, {1'b1, 5'd3});
    req1 = 1'b1; we1 = 1'b0; addr1 = 5'd9; wdata1 = '0;
    tick();
    chk("late_ack0", {ack0, ack1, rdata0}, {1'b1, 1'b0, 16'h1003});
    req0 = 1'b0;
    tick();
    chk("late_idle", {busy, ack0, ack1}, 3'b000);
    tick();
    chk("late_grant1", {busy, mem_addr}, {1'b1, 5'd9});
    tick();
    chk("late_ack1", {ack0, ack1, rdata1}, {1'b0, 1'b1, 16'h1009});
    req1 = 1'b0;
    tick();
    chk("late_cnt", {cnt0, cnt1}, {8'd4, 8'd4});

    // Asynchronous reset in the middle of port 1's store SERVE cycle.
    req1 = 1'b1; we1 = 1'b1; addr1 = 5'd9; wdata1 = 16'hAAAA;
    tick();
    chk("rst_serve", {mem_write, mem_addr, mem_wdata}, {1'b1, 5'd9, 16'hAAAA});
    #3 reset = 1'b1;
    #1;
    chk("rst_async", {mem_write, busy, ack0, ack1, cnt0, cnt1, mem_addr}, '0);
    req1 = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_no_write", mem[9], 16'h1009);
    tick();
    chk("rst_no_ack", {ack1, busy}, 2'b00);
    req0 = 1'b1; we0 = 1'b0; addr0 = 5'd9;
    tick();
    chk("rst_next_grant", {busy, mem_addr, mem_write}, {1'b1, 5'd9, 1'b0});
    tick();
    chk("rst_next_ack", {ack0, rdata0}, {1'b1, 16'h1009});
    req0 = 1'b0;
    tick();
    chk("rst_next_cnt", {busy, cnt0, cnt1}, {1'b0, 8'd1, 8'd0});

    // Saturating counter on the CNT_W=2 instance: five back-to-back loads.
    begin
      int acks = 0;
      s_req0 = 1'b1;
      for (int i = 0; i < 15; i++) begin
        tick();
        if (s_ack0) acks++;
        if (i == 8)  chk("sat_cnt_at3", s_cnt0, 2'd3);
        if (i == 11) chk("sat_cnt_stuck", s_cnt0, 2'd3);
      end
      s_req0 = 1'b0;
      tick();
      chk("sat_acks", acks, 5);
      chk("sat_final", {s_cnt0, s_cnt1, s_rdata0, s_busy}, {2'd3, 2'd0, 16'h5A5A, 1'b0});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single-port data memory between the core control unit (port 0, load/store) and an external loader/DMA engine (port 1).
- Each access is a full req/ack transaction. Winners are chosen round-robin, and request fields are latched at grant.
- Drives the data memory address, write-data and write-enable lines. Returns read data and a one-cycle ack to the winner.
- Keeps saturating per-port access counters for debug.

Parameters:
- DATA_W, 16, data word width
- ADDR_W, 5, data memory address width (32 words)
- CNT_W, 8, width of each per-port access counter

Ports:
- clock      in   1        system clock, rising edge
- reset      in   1        asynchronous, active-high
- req0       in   1        port 0 (core) request; hold until ack0
- we0        in   1        port 0: 1 = store, 0 = load
- addr0      in   ADDR_W   port 0 address
- wdata0     in   DATA_W   port 0 store data
- ack0       out  1        port 0 transaction complete (1-cycle pulse)
- rdata0     out  DATA_W   port 0 load data, valid while ack0=1
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1 (loader)
- mem_addr   out  ADDR_W   data memory address
- mem_wdata  out  DATA_W   data memory write data
- mem_write  out  1        data memory write enable (memory writes on rising edge)
- mem_rdata  in   DATA_W   data memory read data, combinational from mem_addr
- busy       out  1        1 when state is not IDLE
- cnt0       out  CNT_W    completed port 0 accesses, saturating
- cnt1       out  CNT_W    completed port 1 accesses, saturating

Behaviour:
- All outputs are registered.
- Reset (asynchronous, takes effect immediately, no clock needed):
  - state=IDLE; last_gnt=1, so port 0 wins the first tie.
  - All ack/rdata/mem_* outputs, busy, cnt0 and cnt1 = 0.
  - A write in flight is aborted: mem_write drops at once. No ack is issued for the aborted access.
- FSM states: IDLE, SERVE, ACK.
- IDLE:
  - Samples req0/req1 at the clock edge.
  - Neither asserted: stay in IDLE.
  - Only one asserted: grant that port.
  - Both asserted: grant the port not equal to last_gnt.
  - On grant: latch the winner's we/addr/wdata into mem_write/mem_addr/mem_wdata, record gnt_id, set last_gnt=gnt_id, go to SERVE.
- SERVE (exactly 1 cycle):
  - mem_* outputs hold the latched values, so the memory write commits at the end-of-SERVE edge.
  - At that edge, mem_rdata is captured into rdata[gnt_id] (loads only; on a store, rdata keeps its old value).
  - Then mem_write←0 and the state goes to ACK.
- ACK (exactly 1 cycle):
  - ack[gnt_id]=1, and rdata[gnt_id] is valid.
  - cnt[gnt_id] increments at the edge leaving ACK, saturating at all-ones.
  - No arbitration occurs in ACK; the state returns to IDLE.
- Latency:
  - A request sampled in IDLE at edge N has mem_write/mem_addr valid from N to N+1 (the SERVE cycle), and its ack high from N+1 to N+2.
  - A request raised while busy waits, and is sampled at the first IDLE edge.
  - Minimum spacing is 3 cycles per access. A requester holding req continuously gets back-to-back accesses every 3 cycles.
- Handshake rules:
  - The requester must keep req and its fields stable until ack.
  - The requester must drop req in the ack cycle unless it wants another access; req still high at the following IDLE edge is a new request.
  - req dropped after the grant edge: the access still completes and ack still pulses.
  - Field changes after grant are ignored.
- Fairness: under continuous requests on both ports the grants alternate 0,1,0,1… No port waits more than one other transaction.
- Outside SERVE: mem_write=0, and mem_addr/mem_wdata hold their last values.
- ack0 and ack1 are never high together. busy=1 in SERVE and ACK.

Test Plan:
- Single store then load, port 0: req0/we0=1/addr0=5/wdata0=16'hBEEF → mem_write=1, addr=5 one cycle after the grant edge; ack0 one cycle later. Then load addr 5 → rdata0=16'hBEEF with ack0; cnt0=2.
- Simultaneous requests from reset: req0 (load addr 3) and req1 (store addr 7, 16'h1234) raised together and held → port 0 served first, port 1 next. ack0 and ack1 are 3 cycles apart and never overlap.
- Continuous contention: both ports hold req for 12 cycles → grant order 0,1,0,1; cnt0=2, cnt1=2.
- Request raised during busy: req1 raised in port 0's SERVE cycle → port 1 granted at the first IDLE edge; ack1 exactly 3 cycles after ack0.
- Asynchronous reset during port 1's SERVE store to addr 9, 16'hAAAA, asserted mid-cycle → mem_write drops immediately; no ack1; busy=0; counters=0; next port 0 request is served normally.
- Counter saturation with CNT_W=2: 5 port 0 accesses → cnt0 sticks at 3, and all 5 accesses still ack.
